vgachargen_mem_ctrl: RTL

- Bus-side controller sequencing all CPU accesses to the text-mode memories: character map (80x30 x 8 bit), colour map (80x30 x 8 bit) and writable character table (128 x 128 bit).
- Accepts one 32-bit word request at a time, decodes the region, and issues byte-serial map accesses or read-modify-write char-table accesses on port A of each BRAM.
- Returns read data with a single-cycle ready pulse.
- Sits between the APB slave front-end and the text-mode display top.

---
 rtl/vgachargen_mem_ctrl_if.sv | 22 ++
 rtl/vgachargen_mem_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vgachargen_mem_ctrl_if.sv
// CPU-side word request bus into the text-mode memory controller.
// One request in flight; requester holds req_i until the ready_o pulse.
interface vgachargen_mem_ctrl_if;
   logic        req_i;
   logic        we_i;
   logic [11:0] addr_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, we_i, addr_i, be_i, wdata_i,
      input  ready_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, be_i, wdata_i,
      output ready_o, rdata_o, err_o
   );
endinterface

// File: rtl/vgachargen_mem_ctrl.sv
// Sequences CPU word accesses onto char map, colour map (byte-serial) and char table (RMW).
// Latency 1 (error) / 3-4 (char table) / 5-6 (maps) cycles; the requester is stalled until ready_o.
module vgachargen_mem_ctrl #(
   parameter int MAP_WORDS = 600,
   parameter int CT_WORDS  = 512
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   vgachargen_mem_ctrl_if.slave   bus,
   output logic [11:0]            ch_map_addr_o,
   output logic                   ch_map_wen_o,
   output logic [7:0]             ch_map_wdata_o,
   input  logic [7:0]             ch_map_rdata_i,
   output logic [11:0]            col_map_addr_o,
   output logic                   col_map_wen_o,
   output logic [7:0]             col_map_wdata_o,
   input  logic [7:0]             col_map_rdata_i,
   output logic [6:0]             ch_t_addr_o,
   output logic                   ch_t_wen_o,
   output logic [127:0]           ch_t_wdata_o,
   input  logic [127:0]           ch_t_rdata_i
);

   localparam logic [10:0] MAP_LIM = 11'(MAP_WORDS);
   localparam logic [10:0] CT_LIM  = 11'(CT_WORDS);

   typedef enum logic [2:0] {
      IDLE, MAP_SEQ, MAP_DRAIN, CT_RD, CT_CAP, CT_WR, RESP
   } state_e;

   state_e         state_q,  state_d;
   logic           we_q,     we_d;
   logic [1:0]     region_q, region_d;
   logic [9:0]     idx_q,    idx_d;
   logic [3:0]     be_q,     be_d;
   logic [31:0]    wdata_q,  wdata_d;
   logic [1:0]     lane_q,   lane_d;
   logic           err_q,    err_d;
   logic [23:0]    rbuf_q,   rbuf_d;
   logic [127:0]   line_q,   line_d;
   logic [31:0]    rdata_q,  rdata_d;

   logic           req_err;
   logic [7:0]     map_rbyte;
   logic [6:0]     word_lsb;
   logic           ch_sel, col_sel, map_wen;
   logic [11:0]    map_addr;
   logic [7:0]     map_byte;

   assign map_rbyte = region_q[0] ? col_map_rdata_i : ch_map_rdata_i;
   assign word_lsb  = {idx_q[1:0], 5'd0};

   always_comb begin
      req_err = 1'b0;
      case (bus.addr_i[11:10])
         2'b00, 2'b01: req_err = ({1'b0, bus.addr_i[9:0]} >= MAP_LIM);
         2'b10:        req_err = ({1'b0, bus.addr_i[9:0]} >= CT_LIM);
         default:      req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      region_d = region_q;
      idx_d    = idx_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      lane_d   = lane_q;
      err_d    = err_q;
      rbuf_d   = rbuf_q;
      line_d   = line_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               we_d     = bus.we_i;
               region_d = bus.addr_i[11:10];
               idx_d    = bus.addr_i[9:0];
               be_d     = bus.be_i;
               wdata_d  = bus.wdata_i;
               lane_d   = 2'd0;
               err_d    = req_err;
               if (req_err) begin
                  rdata_d = '0;
                  state_d = RESP;
               end else if (!bus.addr_i[11]) begin
                  state_d = MAP_SEQ;
               end else begin
                  state_d = CT_RD;
               end
            end
         end
         MAP_SEQ: begin
            lane_d = lane_q + 2'd1;
            // BRAM data lags the address by one cycle, so lane L returns byte L-1
            if (!we_q && lane_q != 2'd0) begin
               rbuf_d[{lane_q - 2'd1, 3'd0} +: 8] = map_rbyte;
            end
            if (lane_q == 2'd3) begin
               if (we_q) begin
                  rdata_d = '0;
                  state_d = RESP;
               end else begin
                  state_d = MAP_DRAIN;
               end
            end
         end
         MAP_DRAIN: begin
            rdata_d = {map_rbyte, rbuf_q};
            state_d = RESP;
         end
         CT_RD: begin
            state_d = CT_CAP;
         end
         CT_CAP: begin
            if (we_q) begin
               line_d = ch_t_rdata_i;
               for (int b = 0; b < 4; b++) begin
                  if (be_q[b]) begin
                     line_d[word_lsb + 7'(8 * b) +: 8] = wdata_q[5'(8 * b) +: 8];
                  end
               end
               state_d = CT_WR;
            end else begin
               rdata_d = ch_t_rdata_i[word_lsb +: 32];
               state_d = RESP;
            end
         end
         CT_WR: begin
            rdata_d = '0;
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         region_q <= 2'd0;
         idx_q    <= 10'd0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         lane_q   <= 2'd0;
         err_q    <= 1'b0;
         rbuf_q   <= 24'd0;
         line_q   <= 128'd0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         region_q <= region_d;
         idx_q    <= idx_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         lane_q   <= lane_d;
         err_q    <= err_d;
         rbuf_q   <= rbuf_d;
         line_q   <= line_d;
         rdata_q  <= rdata_d;
      end
   end

   assign ch_sel   = (state_q == MAP_SEQ) && (region_q == 2'b00);
   assign col_sel  = (state_q == MAP_SEQ) && (region_q == 2'b01);
   assign map_addr = {idx_q, lane_q};
   assign map_byte = wdata_q[{lane_q, 3'd0} +: 8];
   assign map_wen  = we_q && be_q[lane_q];

   assign ch_map_addr_o   = ch_sel ? map_addr : 12'd0;
   assign ch_map_wen_o    = ch_sel && map_wen;
   assign ch_map_wdata_o  = (ch_sel && map_wen) ? map_byte : 8'd0;
   assign col_map_addr_o  = col_sel ? map_addr : 12'd0;
   assign col_map_wen_o   = col_sel && map_wen;
   assign col_map_wdata_o = (col_sel && map_wen) ? map_byte : 8'd0;

   assign ch_t_addr_o  = (state_q == CT_RD || state_q == CT_WR) ? idx_q[8:2] : 7'd0;
   assign ch_t_wen_o   = (state_q == CT_WR);
   assign ch_t_wdata_o = (state_q == CT_WR) ? line_q : 128'd0;

   assign bus.ready_o = (state_q == RESP);
   assign bus.err_o   = (state_q == RESP) && err_q;
   assign bus.rdata_o = rdata_q;

endmodule
